// File: rtl/operand_loader.sv
// Byte-stream operand loader for the 32-bit adder: assembles numberA then numberB (little-endian),
// plus carry-in when `OPERAND_CI_EN is defined, and presents the complete set with a valid/ready handshake.
module operand_loader #(
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] numberA,
  output logic [31:0] numberB,
  output logic        ci,
  output logic        op_valid,
  input  logic        op_ready,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    COLLECT_A  = 2'd0,
    COLLECT_B  = 2'd1,
    COLLECT_CI = 2'd2,
    PRESENT    = 2'd3
  } state_t;

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_idx, w_idx_nxt;
  logic [31:0] r_sh_a, r_sh_b, w_sh_a_nxt, w_sh_b_nxt;
  logic [31:0] r_num_a, r_num_b;
  logic        w_accept, w_running, w_abort, w_load;

  assign in_ready = (r_state != PRESENT);
  assign op_valid = (r_state == PRESENT);
  assign w_accept = in_valid && in_ready;
  assign numberA  = r_num_a;
  assign numberB  = r_num_b;

  // A set counts as "started" once any byte of it has been accepted.
  assign w_running = (r_state == COLLECT_B) || (r_state == COLLECT_CI) ||
                     ((r_state == COLLECT_A) && (r_idx != 2'd0));

`ifdef OPERAND_CI_EN
  logic r_sh_ci, w_sh_ci_nxt, r_ci;
  assign ci = r_ci;
`else
  assign ci = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_sh_a_nxt  = r_sh_a;
    w_sh_b_nxt  = r_sh_b;
`ifdef OPERAND_CI_EN
    w_sh_ci_nxt = r_sh_ci;
`endif
    case (r_state)
      COLLECT_A: begin
        if (w_accept) begin
          w_sh_a_nxt[{r_idx, 3'b000} +: 8] = in_data;
          w_idx_nxt = r_idx + 2'd1;
          if (r_idx == 2'd3) w_state_nxt = COLLECT_B;
        end
      end
      COLLECT_B: begin
        if (w_accept) begin
          w_sh_b_nxt[{r_idx, 3'b000} +: 8] = in_data;
          w_idx_nxt = r_idx + 2'd1;
`ifdef OPERAND_CI_EN
          if (r_idx == 2'd3) w_state_nxt = COLLECT_CI;
`else
          if (r_idx == 2'd3) w_state_nxt = PRESENT;
`endif
        end
      end
      COLLECT_CI: begin
`ifdef OPERAND_CI_EN
        if (w_accept) begin
          w_sh_ci_nxt = in_data[0];
          w_state_nxt = PRESENT;
        end
`else
        w_state_nxt = COLLECT_A;
`endif
      end
      PRESENT: begin
        if (op_ready) w_state_nxt = COLLECT_A;
      end
    endcase
    // Abort drops the partial set; presented outputs are untouched.
    if (w_abort) begin
      w_state_nxt = COLLECT_A;
      w_idx_nxt   = 2'd0;
      w_sh_a_nxt  = '0;
      w_sh_b_nxt  = '0;
`ifdef OPERAND_CI_EN
      w_sh_ci_nxt = 1'b0;
`endif
    end
  end

  assign w_load = (r_state != PRESENT) && (w_state_nxt == PRESENT);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= COLLECT_A;
      r_idx   <= 2'd0;
      r_sh_a  <= '0;
      r_sh_b  <= '0;
      r_num_a <= '0;
      r_num_b <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_sh_a  <= w_sh_a_nxt;
      r_sh_b  <= w_sh_b_nxt;
      // Load from the next-shadow values so the final byte lands on the same edge.
      if (w_load) begin
        r_num_a <= w_sh_a_nxt;
        r_num_b <= w_sh_b_nxt;
      end
    end
  end

`ifdef OPERAND_CI_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sh_ci <= 1'b0;
      r_ci    <= 1'b0;
    end else begin
      r_sh_ci <= w_sh_ci_nxt;
      if (w_load) r_ci <= w_sh_ci_nxt;
    end
  end
`endif

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_to
      logic [CW-1:0] r_to_cnt;
      logic          r_to_err;

      // An accept on what would be the limit cycle wins: abort requires no accept.
      assign w_abort     = w_running && !w_accept && (r_to_cnt == CW'(TIMEOUT_CYCLES - 1));
      assign timeout_err = r_to_err;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_to_cnt <= '0;
          r_to_err <= 1'b0;
        end else begin
          r_to_err <= w_abort;
          if (!w_running || w_accept || w_abort) r_to_cnt <= '0;
          else                                   r_to_cnt <= r_to_cnt + CW'(1);
        end
      end
    end else begin : g_no_to
      assign w_abort     = 1'b0;
      assign timeout_err = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_operand_loader.sv
// Randomized + directed bench for operand_loader against a queue-based set model (TIMEOUT_CYCLES=8).
module tb_operand_loader;
  localparam int TO = 8;
`ifdef OPERAND_CI_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        op_ready = 1'b0;
  logic        in_ready, ci, op_valid, timeout_err;
  logic [31:0] numberA, numberB;

  always #5 clk = ~clk;

  operand_loader #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .numberA(numberA), .numberB(numberB), .ci(ci), .op_valid(op_valid), .op_ready(op_ready),
    .timeout_err(timeout_err)
  );

  int n_chk = 0;
  int n_err = 0;
  int terr_seen = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: collect accepted bytes of the current set in a queue; a full set becomes the outputs.
  logic [7:0]  mq[$];
  logic [31:0] m_a = 0, m_b = 0;
  logic        m_ci = 0, m_valid = 0, m_terr = 0;
  int          m_idle = 0;

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      m_a = 0; m_b = 0; m_ci = 0; m_valid = 0; m_terr = 0; m_idle = 0;
    end else begin
      m_terr = 0;
      if (m_valid) begin
        if (op_ready) m_valid = 0;
      end else if (in_valid) begin
        mq.push_back(in_data);
        m_idle = 0;
        if (mq.size() == NB) begin
          m_a = {mq[3], mq[2], mq[1], mq[0]};
          m_b = {mq[7], mq[6], mq[5], mq[4]};
          m_ci = (NB == 9) ? mq[NB-1][0] : 1'b0;
          m_valid = 1;
          mq.delete();
        end
      end else if (mq.size() > 0) begin
        m_idle++;
        if (m_idle == TO) begin
          mq.delete();
          m_idle = 0;
          m_terr = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("op_valid", op_valid, m_valid);
    chk("in_ready", in_ready, !m_valid);
    chk("numberA", numberA, m_a);
    chk("numberB", numberB, m_b);
    chk("ci", ci, m_ci);
    chk("timeout_err", timeout_err, m_terr);
    if (timeout_err) terr_seen++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    logic acc;
    in_valid = 1'b1;
    in_data  = b;
    do begin
      acc = in_ready;
      tick();
      n++;
    end while (!acc && n < 50);
    if (!acc) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!op_valid && n < 50) begin
      tick();
      n++;
    end
    chk(tag, op_valid, 1);
  endtask

  task automatic handshake();
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
  endtask

  task automatic send_set(input logic [31:0] a, input logic [31:0] b, input logic [7:0] cb, input int gap);
    for (int i = 0; i < 4; i++) begin
      send_byte(a[i*8 +: 8]);
      if (gap > 0) idle($urandom_range(0, gap));
    end
    for (int i = 0; i < 4; i++) begin
      send_byte(b[i*8 +: 8]);
      if (gap > 0 && i < 3) idle($urandom_range(0, gap));
    end
`ifdef OPERAND_CI_EN
    if (gap > 0) idle($urandom_range(0, gap));
    send_byte(cb);
`endif
  endtask

  task automatic load_and_check(input string tag, input logic [31:0] a, input logic [31:0] b,
                                input logic [7:0] cb, input int gap);
    send_set(a, b, cb, gap);
    wait_valid({tag, "_valid"});
    chk({tag, "_A"}, numberA, a);
    chk({tag, "_B"}, numberB, b);
    chk({tag, "_ci"}, ci, (NB == 9) ? cb[0] : 1'b0);
    handshake();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    // reset state
    reset = 1'b1;
    tick(); tick();
    chk("rst_A", numberA, 0);
    chk("rst_B", numberB, 0);
    chk("rst_valid", op_valid, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_terr", timeout_err, 0);
    reset = 1'b0;

    // 1: back-to-back set, op_valid visible right after last accept
    send_set(32'd64, 32'd128, 8'h00, 0);
    chk("t1_valid_next", op_valid, 1);
    chk("t1_A", numberA, 32'd64);
    chk("t1_B", numberB, 32'd128);
    chk("t1_ci", ci, 0);

    // 2: backpressure in PRESENT with a pending byte
    in_valid = 1'b1;
    in_data  = 8'h11;
    repeat (5) begin
      tick();
      chk("t2_hold_ready", in_ready, 0);
      chk("t2_hold_A", numberA, 32'd64);
    end
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
    chk("t2_valid_drop", op_valid, 0);
    chk("t2_ready_up", in_ready, 1);
    tick();
    in_valid = 1'b0;
    send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
`ifdef OPERAND_CI_EN
    send_byte(8'h00);
`endif
    wait_valid("t2_valid");
    chk("t2_A", numberA, 32'h44332211);
    chk("t2_B", numberB, 32'h88776655);
    handshake();

    // 3: random gaps below the timeout
    snap = terr_seen;
    load_and_check("t3", 32'hFFFFFFFF, 32'h1, 8'h00, 3);
    chk("t3_no_terr", terr_seen - snap, 0);

    // 4: timeout after 3 bytes, then recovery, then byte on the limit cycle
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    idle(TO);
    chk("t4_pulse", timeout_err, 1);
    chk("t4_A_keep", numberA, 32'hFFFFFFFF);
    chk("t4_valid", op_valid, 0);
    chk("t4_ready", in_ready, 1);
    tick();
    chk("t4_pulse_end", timeout_err, 0);
    load_and_check("t4_full", 32'h12345678, 32'h9ABCDEF0, 8'h01, 0);
    snap = terr_seen;
    send_byte(8'h0A); send_byte(8'h0B); send_byte(8'h0C);
    idle(TO - 1);
    send_set_tail();
    wait_valid("t4_late_valid");
    chk("t4_late_A", numberA, 32'h0D0C0B0A);
    chk("t4_late_B", numberB, 32'h04030201);
    chk("t4_late_no_terr", terr_seen - snap, 0);
    handshake();

    // 5: reset mid-load
    send_byte(8'h5A); send_byte(8'h5B); send_byte(8'h5C); send_byte(8'h5D); send_byte(8'h5E);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_A", numberA, 0);
    chk("t5_B", numberB, 0);
    chk("t5_ci", ci, 0);
    chk("t5_valid", op_valid, 0);
    load_and_check("t5", 32'h1, 32'h2, 8'h00, 0);

    // 6: carry-in byte
    load_and_check("t6_ci3", 32'hCAFEF00D, 32'h0BADBEEF, 8'h03, 0);
    load_and_check("t6_ciFE", 32'h00000010, 32'h00000020, 8'hFE, 0);
`ifdef OPERAND_CI_EN
    for (int i = 0; i < 8; i++) send_byte(8'(i + 1));
    idle(2);
    chk("t6_wait_9th", op_valid, 0);
    send_byte(8'h01);
    chk("t6_after_9th", op_valid, 1);
    handshake();
`endif

    // random traffic, occasional long idles and resets
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 49) == 0) begin
        in_valid = 1'b0;
        op_ready = 1'($urandom_range(0, 1));
        repeat (TO + 2) tick();
      end
      reset    = ($urandom_range(0, 299) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = 8'($urandom);
      op_ready = 1'($urandom_range(0, 1));
      tick();
    end
    reset = 1'b0;
    in_valid = 1'b0;
    op_ready = 1'b0;
    tick(); tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Remaining bytes after the late-arriving 4th byte of A in test 4.
  task automatic send_set_tail();
    send_byte(8'h0D);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
`ifdef OPERAND_CI_EN
    send_byte(8'h00);
`endif
  endtask

endmodule
